// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the modulo-N index step.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  function automatic int unsigned next_idx(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker.
// Returns the first valid index at or after ptr_i, wrapping modulo N_REQ.
module fifo_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int j;

  // Scan from the far end so the last hit is the nearest to ptr_i.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port
// between N_REQ valid/ready producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  output logic                        grant_active,
  output logic [IDX_W-1:0]            grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             in_burst;
  logic             cap_hit;
  logic             burst_end;

  assign in_burst  = (state_q == ARB_BURST);
  assign owner_nxt = IDX_W'(next_idx(32'(owner_q), N_REQ));

  // One picker serves both the idle grant and the burst-end re-pick.
  assign pick_ptr = in_burst ? owner_nxt : rr_ptr_q;

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (!rst && in_burst && !fifo_full)
      req_ready[owner_q] = 1'b1;
  end

  assign fifo_w_en    = req_valid[owner_q] & req_ready[owner_q];
  assign fifo_data_in = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign cap_hit      = fifo_w_en && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign burst_end    = in_burst && (!req_valid[owner_q] || cap_hit);

  assign grant_active = in_burst;
  assign grant_id     = owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            state_q <= ARB_BURST;
            owner_q <= pick_idx;
            cnt_q   <= '0;
          end
        end
        ARB_BURST: begin
          if (burst_end) begin
            rr_ptr_q <= owner_nxt;
            cnt_q    <= '0;
            if (pick_found)
              owner_q <= pick_idx;
            else
              state_q <= ARB_IDLE;
          end else if (fifo_w_en) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed
// sequences and randomized traffic against a queue-based model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_full;
  logic            grant_active;
  logic [1:0]      grant_id;

  logic        rst2;
  logic [2:0]  v2;
  logic [23:0] d2;
  logic [2:0]  r2;
  logic        w2;
  logic [7:0]  dd2;
  logic        full2;
  logic        ga2;
  logic [1:0]  gid2;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .grant_active(grant_active), .grant_id(grant_id)
  );

  fifo_wr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(v2), .req_data(d2),
    .req_ready(r2), .fifo_w_en(w2), .fifo_data_in(dd2),
    .fifo_full(full2), .grant_active(ga2), .grant_id(gid2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic [7:0] d0;
    logic [3:0] er;
    logic       ew;
    logic       ega;
    logic [1:0] egid;
    logic [7:0] edin;
  } vec_t;

  vec_t tv[24];

  // Model state: who holds the port, beats taken, rotation pointer.
  bit  m_act;
  int  m_own, m_cnt, m_ptr;
  logic [7:0] pq[N][$];
  logic [7:0] fq[$];
  logic [7:0] eq[$];
  bit  lw;
  logic [7:0] ld;

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int busy();
    int b = fq.size();
    for (int i = 0; i < N; i++) b += pq[i].size();
    return b;
  endfunction

  task automatic step(input logic r, input bit rd, input bit ck);
    logic [N-1:0] v;
    logic [N-1:0] er;
    logic [7:0]   d;
    bit acc;
    int w;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < N; i++) begin
      v[i] = (pq[i].size() != 0);
      req_data[i*DW +: DW] = v[i] ? pq[i][0] : 8'h00;
    end
    req_valid = v;
    fifo_full = (fq.size() == 8);
    #1;
    er  = (!r && m_act && !fifo_full) ? (N'(1) << m_own) : '0;
    acc = er[m_own] && v[m_own];
    if (ck) begin
      chk("ready", 32'(req_ready), 32'(er));
      chk("w_en", 32'(fifo_w_en), 32'(acc));
      chk("grant_active", 32'(grant_active), 32'(m_act));
      chk("grant_id", 32'(grant_id), 32'(m_own));
      if (acc) chk("data", 32'(fifo_data_in), 32'(pq[m_own][0]));
    end
    if (acc) eq.push_back(pq[m_own][0]);
    lw = fifo_w_en;
    ld = fifo_data_in;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i] && pq[i].size() != 0)
        void'(pq[i].pop_front());
    if (fifo_w_en && !fifo_full) fq.push_back(fifo_data_in);
    if (rd && fq.size() != 0) begin
      d = fq.pop_front();
      if (ck) begin
        if (eq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fifo_read actual=%0h expected=none", d);
        end else begin
          chk("fifo_read", 32'(d), 32'(eq.pop_front()));
        end
      end else if (eq.size() != 0) begin
        void'(eq.pop_front());
      end
    end
    if (r) begin
      m_act = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_act) begin
      w = first_from(v, m_ptr);
      if (w >= 0) begin m_act = 1; m_own = w; m_cnt = 0; end
    end else begin
      if (acc) m_cnt++;
      if (!v[m_own] || m_cnt == MB) begin
        m_ptr = (m_own + 1) % N;
        m_cnt = 0;
        w = first_from(v, m_ptr);
        if (w >= 0) m_own = w;
        else m_act = 0;
      end
    end
  endtask

  initial begin
    int first_c, last_c, n1;
    bit seen2;
    logic [7:0] wlog[$];

    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    rst2 = 1'b1; v2 = '0; d2 = '0; full2 = 1'b0;

    tv[0]  = '{1'b1, 4'b0000, 1'b0, 8'hA1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA1};
    tv[1]  = '{1'b0, 4'b0001, 1'b0, 8'hA1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA1};
    tv[2]  = '{1'b0, 4'b0001, 1'b0, 8'hA1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA1};
    tv[3]  = '{1'b0, 4'b0001, 1'b0, 8'hA2, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA2};
    tv[4]  = '{1'b0, 4'b0001, 1'b0, 8'hA3, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA3};
    tv[5]  = '{1'b0, 4'b0000, 1'b0, 8'hA3, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hA3};
    tv[6]  = '{1'b0, 4'b0000, 1'b0, 8'hA3, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA3};
    tv[7]  = '{1'b1, 4'b0000, 1'b0, 8'hA4, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA4};
    tv[8]  = '{1'b0, 4'b0101, 1'b0, 8'hA4, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA4};
    tv[9]  = '{1'b0, 4'b0101, 1'b0, 8'hA4, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA4};
    tv[10] = '{1'b0, 4'b0101, 1'b0, 8'hA5, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA5};
    tv[11] = '{1'b0, 4'b0100, 1'b0, 8'hA5, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hA5};
    tv[12] = '{1'b0, 4'b0100, 1'b0, 8'hA5, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h2F};
    tv[13] = '{1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2F};
    tv[14] = '{1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2F};
    tv[15] = '{1'b0, 4'b0100, 1'b0, 8'hA5, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h2F};
    tv[16] = '{1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h2F};
    tv[17] = '{1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h2F};
    tv[18] = '{1'b0, 4'b1010, 1'b0, 8'hA5, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h2F};
    tv[19] = '{1'b0, 4'b1010, 1'b0, 8'hA5, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h3F};
    tv[20] = '{1'b1, 4'b1010, 1'b0, 8'hA5, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h3F};
    tv[21] = '{1'b0, 4'b1010, 1'b0, 8'hA5, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA5};
    tv[22] = '{1'b0, 4'b1010, 1'b0, 8'hA5, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h1F};
    tv[23] = '{1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h1F};

    repeat (2) @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      rst       = tv[k].rst;
      req_valid = tv[k].v;
      fifo_full = tv[k].full;
      req_data  = {8'h3F, 8'h2F, 8'h1F, tv[k].d0};
      #1;
      chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(tv[k].er));
      chk($sformatf("vec%0d_w_en", k), 32'(fifo_w_en), 32'(tv[k].ew));
      chk($sformatf("vec%0d_gact", k), 32'(grant_active), 32'(tv[k].ega));
      chk($sformatf("vec%0d_gid", k), 32'(grant_id), 32'(tv[k].egid));
      chk($sformatf("vec%0d_din", k), 32'(fifo_data_in), 32'(tv[k].edin));
    end

    // All four producers streaming with the reader draining.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 8; s++) pq[i].push_back(8'((i << 4) | s));
    first_c = -1; last_c = -1;
    for (int c = 0; c < 100 && wlog.size() < 32; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (lw) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        wlog.push_back(ld);
      end
    end
    chk("rr_count", 32'(wlog.size()), 32'd32);
    for (int k = 0; k < wlog.size() && k < 32; k++)
      chk($sformatf("rr_order%0d", k), 32'(wlog[k]),
          32'((((k / 4) % 4) << 4) | ((k / 16) * 4 + k % 4)));
    chk("rr_no_bubble", 32'(last_c - first_c + 1), 32'd32);
    for (int c = 0; c < 200 && busy() != 0; c++) step(1'b0, 1'b1, 1'b1);

    // Full stall while req1 owns the port with one beat done.
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      fq.push_back(8'hE0 + 8'(k));
      eq.push_back(8'hE0 + 8'(k));
    end
    for (int s = 0; s < 8; s++) pq[1].push_back(8'h10 + 8'(s));
    for (int s = 0; s < 4; s++) pq[2].push_back(8'h20 + 8'(s));
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("stall_full", 32'(fq.size()), 32'd8);
    repeat (5) begin
      step(1'b0, 1'b0, 1'b1);
      chk("stall_owner", 32'(grant_id), 32'd1);
    end
    n1 = 0; seen2 = 0;
    for (int c = 0; c < 200 && busy() != 0; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (lw && ld[7:4] == 4'h2) seen2 = 1;
      if (lw && ld[7:4] == 4'h1 && !seen2) n1++;
    end
    chk("stall_resume_beats", 32'(n1), 32'd3);
    chk("stall_drain", 32'(busy()), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 3 && $urandom_range(0, 3) == 0)
          pq[i].push_back(8'($urandom));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 1'b1);
    end
    for (int c = 0; c < 300 && busy() != 0; c++) step(1'b0, 1'b1, 1'b1);
    chk("rand_drain", 32'(busy() + eq.size()), 32'd0);

    // N_REQ=3, MAX_BURST=1: strict one-beat alternation.
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; v2 = 3'b111; d2 = {8'h02, 8'h01, 8'h00};
    #1;
    chk("alt_idle_wen", 32'(w2), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("alt%0d_wen", k), 32'(w2), 32'd1);
      chk($sformatf("alt%0d_id", k), 32'(dd2), 32'(k % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
